// File: rtl/keq_sequencer_pkg.sv
// Shared constants and state encoding for the key-equation sequencer.
package keq_sequencer_pkg;

   // Correction capability and datapath widths
   localparam int unsigned T       = 8;
   localparam int unsigned DEG_W   = 5;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned MAX_CYC = 20;

   // Initial degrees injected into the chain: deg R = 2T, deg Q = 2T-1
   localparam logic [DEG_W-1:0] DEG_R_INIT = DEG_W'(2 * T);
   localparam logic [DEG_W-1:0] DEG_Q_INIT = DEG_W'(2 * T - 1);

   // Decoder failure threshold for the evaluator degree
   localparam logic [DEG_W-1:0] DEG_T = DEG_W'(T);

   // Last RUN cycle before the timeout fires (cnt counts from 0)
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYC - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StInit = 2'd1,
      StRun  = 2'd2,
      StDone = 2'd3
   } keq_state_e;

   // Increment that sticks at the all-ones value instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
   endfunction

endpackage

// File: rtl/keq_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
module keq_sequencer_sat_counter #(
   parameter int unsigned Width = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [Width-1:0] count
);

   // Clear has priority over enable; count sticks at all-ones
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != {Width{1'b1}})) begin
         count <= count + Width'(1);
      end
   end

endmodule

// File: rtl/keq_sequencer.sv
// Control end of the Euclidean key-equation array (t=8, GF(2^13) BCH).
// Optional swap counter is built only when KEQ_SWAP_COUNT_EN is defined.
module keq_sequencer
   import keq_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             synd_valid,
   output logic             synd_ready,
   output logic             start,
   output logic [DEG_W-1:0] deg_r_init,
   output logic [DEG_W-1:0] deg_q_init,
   input  logic             stop_i,
   input  logic             sw_i,
   input  logic [DEG_W-1:0] deg_r_fin,
   input  logic [DEG_W-1:0] deg_q_fin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DEG_W-1:0] res_deg_r,
   output logic [DEG_W-1:0] res_deg_q,
   output logic [CNT_W-1:0] res_iter,
   output logic             res_fail,
   output logic [CNT_W-1:0] swap_cnt
);

   keq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt;

   logic             synd_ready_d;
   logic             start_d;
   logic [DEG_W-1:0] deg_r_init_d;
   logic [DEG_W-1:0] deg_q_init_d;
   logic             res_valid_d;
   logic             res_latch;
   logic             res_fail_d;

   // RUN-cycle counter, restarted on every INIT
   keq_sequencer_sat_counter #(
      .Width (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == StInit),
      .enable (state_q == StRun),
      .count  (cnt)
   );

`ifdef KEQ_SWAP_COUNT_EN
   // Swap counter only advances inside RUN, so it freezes through DONE
   keq_sequencer_sat_counter #(
      .Width (CNT_W)
   ) u_swap_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == StInit),
      .enable ((state_q == StRun) && sw_i),
      .count  (swap_cnt)
   );
`else
   logic unused_sw;
   assign unused_sw = sw_i;
   assign swap_cnt  = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stop and timeout both leave RUN
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (synd_valid) state_d = StInit;
         StInit: state_d = StRun;
         StRun:  if (stop_i || (cnt == CNT_LAST)) state_d = StDone;
         StDone: if (res_valid && res_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output next values, decoded from the upcoming state so outputs stay registered
   always_comb begin
      synd_ready_d = (state_d == StIdle);
      start_d      = (state_d == StInit);
      deg_r_init_d = (state_d == StInit) ? DEG_R_INIT : '0;
      deg_q_init_d = (state_d == StInit) ? DEG_Q_INIT : '0;
      res_valid_d  = (state_d == StDone);
      res_latch    = (state_q == StRun) && (state_d == StDone);
      // A stop on the timeout cycle wins: only the degree check decides
      res_fail_d   = stop_i ? (deg_r_fin >= DEG_T) : 1'b1;
   end

   // Output registers; result fields are captured once when RUN ends
   always_ff @(posedge clk) begin
      if (reset) begin
         synd_ready <= 1'b1;
         start      <= 1'b0;
         deg_r_init <= '0;
         deg_q_init <= '0;
         res_valid  <= 1'b0;
         res_deg_r  <= '0;
         res_deg_q  <= '0;
         res_iter   <= '0;
         res_fail   <= 1'b0;
      end else begin
         synd_ready <= synd_ready_d;
         start      <= start_d;
         deg_r_init <= deg_r_init_d;
         deg_q_init <= deg_q_init_d;
         res_valid  <= res_valid_d;
         if (res_latch) begin
            res_deg_r <= deg_r_fin;
            res_deg_q <= deg_q_fin;
            res_iter  <= sat_inc(cnt);
            res_fail  <= res_fail_d;
         end
      end
   end

endmodule
